// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue/capture sequencer sitting in front of a combinational 4-bit ALU.
// One command in flight at a time; results are held in a valid/ready response register.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4,
  parameter int RES_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [DATA_W-1:0]        cmd_a,
  input  logic [DATA_W-1:0]        cmd_b,
  input  logic [1:0]               cmd_op,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [1:0]               alu_op,
  input  logic [RES_W-1:0]         alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [RES_W-1:0]         rsp_result,
  output logic [1:0]               rsp_op,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

  state_e                 state_q, state_d;
  cmd_t [DEPTH-1:0]       mem_q, mem_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [DATA_W-1:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]             alu_op_q, alu_op_d, rsp_op_q, rsp_op_d;
  logic [RES_W-1:0]       rsp_result_q, rsp_result_d;
  logic                   rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic                   push, pop, hs, mod_zero;
  cmd_t                   head;

  always_comb begin
    // No bypass: a full FIFO refuses even when a pop lands in the same cycle.
    cmd_ready = rst_n && (count_q != CNT_FULL);
    push      = cmd_valid && cmd_ready;
    hs        = rsp_valid_q && rsp_ready;
    pop       = (count_q != '0) && ((state_q == IDLE) || ((state_q == HOLD) && hs));
    head      = mem_q[rd_ptr_q];
    mod_zero  = (alu_op_q == 2'b10) && (alu_b_q == '0);

    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    rsp_err_d    = rsp_err_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{a: cmd_a, b: cmd_b, op: cmd_op};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      alu_a_d  = head.a;
      alu_b_d  = head.b;
      alu_op_d = head.op;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: if (pop) state_d = ISSUE;
      ISSUE: begin
        // ALU has had a full cycle to settle on the registered operands.
        rsp_valid_d  = 1'b1;
        rsp_op_d     = alu_op_q;
        rsp_err_d    = mod_zero;
        rsp_result_d = mod_zero ? '0 : alu_result;
        state_d      = HOLD;
      end
      HOLD: if (hs) begin
        rsp_valid_d = 1'b0;
        state_d     = pop ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU drives alu_result, a queue-based model predicts responses.
module tb_alu_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b;
  logic [1:0] cmd_op, alu_op, rsp_op;
  logic [7:0] alu_result, rsp_result;
  logic [2:0] fifo_count;

  typedef struct packed {
    logic [7:0] res;
    logic [1:0] op;
    logic       err;
  } rsp_t;

  rsp_t exp_q[$], obs_q[$];
  int   obs_t[$];
  int   n_chk = 0, n_pass = 0, n_push = 0, cyc = 0;

  alu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_op(rsp_op), .rsp_err(rsp_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Combinational ALU stand-in; modulo by zero yields garbage the sequencer must mask.
  always_comb begin
    case (alu_op)
      2'b00:   alu_result = 8'(alu_a) + 8'(alu_b);
      2'b01:   alu_result = 8'(alu_a) * 8'(alu_b);
      2'b10:   alu_result = (alu_b == 4'd0) ? 8'hAA : 8'(alu_a % alu_b);
      default: alu_result = 8'(alu_a & alu_b);
    endcase
  end

  function automatic rsp_t model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    rsp_t r;
    int ia = int'(a), ib = int'(b);
    r.op = op;
    r.err = 1'b0;
    case (op)
      2'd0:    r.res = 8'(ia + ib);
      2'd1:    r.res = 8'(ia * ib);
      2'd2:    if (ib == 0) begin r.res = 8'd0; r.err = 1'b1; end else r.res = 8'(ia % ib);
      default: r.res = 8'(ia & ib);
    endcase
    return r;
  endfunction

  // Advance one clock; record accepted commands (as predictions) and observed response handshakes.
  task automatic tick();
    bit p, r;
    rsp_t o;
    p = cmd_valid && cmd_ready;
    r = rsp_valid && rsp_ready;
    o = '{rsp_result, rsp_op, rsp_err};
    @(posedge clk);
    cyc++;
    if (p) begin exp_q.push_back(model(cmd_a, cmd_b, cmd_op)); n_push++; end
    if (r) begin obs_q.push_back(o); obs_t.push_back(cyc); end
    @(negedge clk);
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); obs_t.delete(); n_push = 0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); else n_pass++;
    n_chk++; if (fifo_count !== 3'd0) $display("FAIL reset_count got=%0d want=0", fifo_count); else n_pass++;
    n_chk++; if ({alu_a, alu_b, alu_op, rsp_result, rsp_op, rsp_err} !== 23'd0)
      $display("FAIL reset_outputs got=%h want=0", {alu_a, alu_b, alu_op, rsp_result, rsp_op, rsp_err}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (cmd_ready !== 1'b1) $display("FAIL release_cmd_ready got=%b want=1", cmd_ready); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0] ta[6] = '{4'd2, 4'd9, 4'd10, 4'd7, 4'd5, 4'd6};
    logic [3:0] tb[6] = '{4'd3, 4'd8, 4'd3, 4'd13, 4'd0, 4'd4};
    logic [1:0] to[6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
    logic [7:0] tr[6] = '{8'd5, 8'd72, 8'd1, 8'd5, 8'd0, 8'd2};
    logic       te[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] a, b;
    logic [1:0] op;
    logic [7:0] er;
    logic       ee;
    rsp_t       m;
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin
        a = ta[i]; b = tb[i]; op = to[i]; er = tr[i]; ee = te[i];
      end else begin
        a = 4'($urandom); b = 4'($urandom); op = 2'($urandom);
        m = model(a, b, op); er = m.res; ee = m.err;
      end
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      n_chk++; if (fifo_count !== 3'd1 || rsp_valid !== 1'b0)
        $display("FAIL single_push[%0d] count=%0d valid=%b want 1/0", i, fifo_count, rsp_valid); else n_pass++;
      tick();
      n_chk++; if ({alu_a, alu_b, alu_op} !== {a, b, op} || rsp_valid !== 1'b0)
        $display("FAIL single_issue[%0d] alu=%h valid=%b want alu=%h valid=0", i, {alu_a, alu_b, alu_op}, rsp_valid, {a, b, op}); else n_pass++;
      tick();
      n_chk++; if ({rsp_valid, rsp_result, rsp_op, rsp_err} !== {1'b1, er, op, ee})
        $display("FAIL single_rsp[%0d] got v=%b r=%0d op=%0d e=%b want v=1 r=%0d op=%0d e=%b",
                 i, rsp_valid, rsp_result, rsp_op, rsp_err, er, op, ee); else n_pass++;
      tick();
      n_chk++; if (rsp_valid !== 1'b0 || {alu_a, alu_b, alu_op} !== {a, b, op})
        $display("FAIL single_idle[%0d] valid=%b alu=%h want valid=0 alu=%h", i, rsp_valid, {alu_a, alu_b, alu_op}, {a, b, op}); else n_pass++;
    end
    clear_sb();
  endtask

  task automatic test_back_pressure();
    logic [3:0] ca[6], cb[6];
    logic [1:0] co[6];
    int k, start;
    bit seen;
    for (int i = 0; i < 6; i++) begin ca[i] = 4'(i + 1); cb[i] = 4'($urandom); co[i] = 2'($urandom); end
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_a = ca[i]; cmd_b = cb[i]; cmd_op = co[i]; cmd_valid = 1'b1;
      start = n_push; k = 0;
      while (n_push == start && k < 20) begin tick(); k++; end
      n_chk++; if (n_push == start) $display("FAIL bp_accept[%0d] got=stalled want=accepted", i); else n_pass++;
    end
    cmd_a = ca[5]; cmd_b = cb[5]; cmd_op = co[5];
    n_chk++; if (fifo_count !== 3'd4 || cmd_ready !== 1'b0)
      $display("FAIL bp_full count=%0d ready=%b want 4/0", fifo_count, cmd_ready); else n_pass++;
    repeat (3) tick();
    n_chk++; if (n_push !== 5 || fifo_count !== 3'd4)
      $display("FAIL bp_held pushes=%0d count=%0d want 5/4", n_push, fifo_count); else n_pass++;
    rsp_ready = 1'b1;
    k = 0; seen = 0;
    while (n_push < 6 && k < 20) begin
      tick(); k++;
      if (obs_q.size() == 1 && !seen) begin
        seen = 1;
        n_chk++; if (fifo_count !== 3'd3 || n_push !== 5)
          $display("FAIL bp_pop_no_write count=%0d pushes=%0d want 3/5", fifo_count, n_push); else n_pass++;
      end
    end
    n_chk++; if (n_push !== 6) $display("FAIL bp_sixth pushes=%0d want 6", n_push); else n_pass++;
    cmd_valid = 1'b0;
    k = 0;
    while (obs_q.size() < 6 && k < 100) begin tick(); k++; end
    n_chk++; if (obs_q.size() != 6) $display("FAIL bp_drain got=%0d want=6", obs_q.size()); else n_pass++;
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i] || obs_q[i].op !== co[i])
        $display("FAIL bp_order[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    clear_sb();
  endtask

  task automatic test_push_pop();
    int k;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom); cmd_valid = 1'b1;
      tick();
    end
    n_chk++; if (fifo_count !== 3'd2 || rsp_valid !== 1'b1)
      $display("FAIL pp_setup count=%0d valid=%b want 2/1", fifo_count, rsp_valid); else n_pass++;
    cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_chk++; if (fifo_count !== 3'd2 || n_push !== 4)
      $display("FAIL pp_count count=%0d pushes=%0d want 2/4", fifo_count, n_push); else n_pass++;
    k = 0;
    while (obs_q.size() < 4 && k < 50) begin tick(); k++; end
    n_chk++; if (obs_q.size() != 4) $display("FAIL pp_drain got=%0d want=4", obs_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL pp_order[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    clear_sb();
  endtask

  task automatic test_streaming();
    int k = 0;
    rsp_ready = 1'b1;
    while (n_push < 8 && k < 100) begin
      if (!cmd_valid || (cmd_valid && n_push == exp_q.size() && k > 0)) begin end
      cmd_valid = 1'b1;
      if (k == 0 || exp_q.size() != n_push) begin end
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
      // Hold the same command until it is accepted.
      begin
        int start = n_push, j = 0;
        while (n_push == start && j < 20) begin tick(); j++; k++; end
      end
    end
    cmd_valid = 1'b0;
    n_chk++; if (n_push !== 8) $display("FAIL stream_push got=%0d want=8", n_push); else n_pass++;
    k = 0;
    while (obs_q.size() < 8 && k < 100) begin tick(); k++; end
    n_chk++; if (obs_q.size() != 8) $display("FAIL stream_count got=%0d want=8", obs_q.size()); else n_pass++;
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL stream_order[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); else n_pass++;
      if (i > 0) begin
        n_chk++; if (obs_t[i] - obs_t[i-1] != 2)
          $display("FAIL stream_gap[%0d] got=%0d want=2", i, obs_t[i] - obs_t[i-1]); else n_pass++;
      end
    end
    repeat (3) tick();
    n_chk++; if (fifo_count !== 3'd0 || obs_q.size() != 8)
      $display("FAIL stream_end count=%0d rsps=%0d want 0/8", fifo_count, obs_q.size()); else n_pass++;
    clear_sb();
  endtask

  task automatic test_reset_mid();
    bit any_valid = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom); cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    n_chk++; if (fifo_count !== 3'd3 || rsp_valid !== 1'b1)
      $display("FAIL mid_setup count=%0d valid=%b want 3/1", fifo_count, rsp_valid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({cmd_ready, rsp_valid, fifo_count, alu_a, alu_b, alu_op, rsp_result, rsp_op, rsp_err} !== 28'd0)
      $display("FAIL mid_reset_outputs got=%h want=0",
               {cmd_ready, rsp_valid, fifo_count, alu_a, alu_b, alu_op, rsp_result, rsp_op, rsp_err}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    n_chk++; if (cmd_ready !== 1'b1) $display("FAIL mid_release_ready got=%b want=1", cmd_ready); else n_pass++;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) any_valid = 1;
      tick();
    end
    n_chk++; if (any_valid || obs_q.size() != 0 || fifo_count !== 3'd0)
      $display("FAIL mid_no_stale valid_seen=%b rsps=%0d count=%0d want 0/0/0", any_valid, obs_q.size(), fifo_count); else n_pass++;
    clear_sb();
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_back_pressure();
    test_push_pop();
    test_streaming();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
